// File: rtl/rlc_stream_encoder.sv
// Serial run-length encoder: one zigzag coefficient per cycle in, DC-DPCM / AC(run,level) /
// ZRL / EOB symbols out as single-word SRAM writes, with per-channel DC predictors.
module rlc_stream_encoder #(
  parameter int COEF_W = 11,
  parameter int BLK_N  = 64,
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 10,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SYM_W = CH_W + 2 + 4 + COEF_W + 1
) (
  input  logic              clk,
  input  logic              srst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  input  logic [CH_W-1:0]   in_ch,
  input  logic              frame_start,
  output logic              wen,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [SYM_W-1:0]  sram_wdata,
  output logic              blk_done,
  output logic              overflow
);
  localparam int IDX_W = $clog2(BLK_N);
  localparam int RUN_W = (IDX_W > 5) ? IDX_W : 5;

  typedef enum logic [1:0] {S_DC, S_AC, S_ZRL} state_t;
  typedef enum logic [1:0] {SYM_DC, SYM_AC, SYM_ZRL, SYM_EOB} sym_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [RUN_W-1:0]  r_run, w_run_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [COEF_W-1:0] r_pred [NUM_CH];
  logic [COEF_W-1:0] r_held;
  logic              r_held_last;
  logic              r_in_ready, r_wen, r_blk_done, r_overflow, r_any_wr;
  logic [ADDR_W-1:0] r_waddr, r_addr_nxt;
  logic [SYM_W-1:0]  r_wdata;

  logic              w_accept, w_last, w_fs, w_wr, w_done, w_hold;
  logic [CH_W-1:0]   w_pidx, w_sym_ch;
  logic [COEF_W-1:0] w_pred;
  logic [COEF_W:0]   w_diff, w_level;
  logic [3:0]        w_sym_run;
  sym_t              w_sym_type;
  logic [ADDR_W-1:0] w_addr;

  assign w_accept = in_valid & r_in_ready;
  assign w_last   = (r_idx == IDX_W'(BLK_N - 1));
  assign w_pidx   = (int'(in_ch) >= NUM_CH) ? CH_W'(NUM_CH - 1) : in_ch;
  assign w_pred   = frame_start ? '0 : r_pred[w_pidx];
  assign w_diff   = {in_coef[COEF_W-1], in_coef} - {w_pred[COEF_W-1], w_pred};
  assign w_addr   = w_fs ? '0 : r_addr_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_run_nxt   = r_run;
    w_wr        = 1'b0;
    w_done      = 1'b0;
    w_hold      = 1'b0;
    w_fs        = 1'b0;
    w_sym_type  = SYM_DC;
    w_sym_run   = '0;
    w_level     = '0;
    w_sym_ch    = r_ch;
    case (r_state)
      S_DC: if (w_accept) begin
        w_wr        = 1'b1;
        w_level     = w_diff;
        w_sym_ch    = in_ch;
        w_fs        = frame_start;
        w_idx_nxt   = IDX_W'(1);
        w_run_nxt   = '0;
        w_state_nxt = S_AC;
      end
      S_AC: if (w_accept) begin
        w_idx_nxt = r_idx + 1'b1;
        if (in_coef == '0) begin
          if (w_last) begin
            w_wr        = 1'b1;
            w_sym_type  = SYM_EOB;
            w_done      = 1'b1;
            w_state_nxt = S_DC;
          end else begin
            w_run_nxt = r_run + 1'b1;
          end
        end else if (r_run < RUN_W'(16)) begin
          w_wr       = 1'b1;
          w_sym_type = SYM_AC;
          w_sym_run  = r_run[3:0];
          w_level    = {in_coef[COEF_W-1], in_coef};
          w_run_nxt  = '0;
          if (w_last) begin
            w_done      = 1'b1;
            w_state_nxt = S_DC;
          end
        end else begin
          // Long run: first ZRL goes out now, the coefficient waits in r_held
          w_wr        = 1'b1;
          w_sym_type  = SYM_ZRL;
          w_sym_run   = 4'hF;
          w_run_nxt   = r_run - RUN_W'(16);
          w_hold      = 1'b1;
          w_state_nxt = S_ZRL;
        end
      end
      S_ZRL: begin
        w_wr = 1'b1;
        if (r_run >= RUN_W'(16)) begin
          w_sym_type = SYM_ZRL;
          w_sym_run  = 4'hF;
          w_run_nxt  = r_run - RUN_W'(16);
        end else begin
          w_sym_type  = SYM_AC;
          w_sym_run   = r_run[3:0];
          w_level     = {r_held[COEF_W-1], r_held};
          w_run_nxt   = '0;
          w_done      = r_held_last;
          w_state_nxt = r_held_last ? S_DC : S_AC;
        end
      end
      default: w_state_nxt = S_DC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state     <= S_DC;
      r_idx       <= '0;
      r_run       <= '0;
      r_ch        <= '0;
      r_pred      <= '{default: '0};
      r_held      <= '0;
      r_held_last <= 1'b0;
      r_in_ready  <= 1'b0;
      r_wen       <= 1'b1;
      r_waddr     <= '0;
      r_addr_nxt  <= '0;
      r_wdata     <= '0;
      r_blk_done  <= 1'b0;
      r_overflow  <= 1'b0;
      r_any_wr    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_run      <= w_run_nxt;
      r_in_ready <= (w_state_nxt != S_ZRL);
      r_wen      <= ~w_wr;
      r_blk_done <= w_done;
      if (r_state == S_DC && w_accept) begin
        r_ch <= in_ch;
        if (w_fs) r_pred <= '{default: '0};
        r_pred[w_pidx] <= in_coef;
      end
      if (w_hold) begin
        r_held      <= in_coef;
        r_held_last <= w_last;
      end
      if (w_wr) begin
        r_waddr    <= w_addr;
        r_addr_nxt <= w_addr + 1'b1;
        r_wdata    <= {w_sym_ch, w_sym_type, w_sym_run, w_level};
        r_any_wr   <= 1'b1;
        // Address 0 reached by increment (not by reset/frame_start) means the counter wrapped
        if (w_fs) r_overflow <= 1'b0;
        else if (r_any_wr && w_addr == '0) r_overflow <= 1'b1;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign wen        = r_wen;
  assign sram_waddr = r_waddr;
  assign sram_wdata = r_wdata;
  assign blk_done   = r_blk_done;
  assign overflow   = r_overflow;
endmodule
